// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - Y86-64 status codes and memory arbiter state encoding.
package y86_pkg;

    localparam logic [1:0] STAT_AOK = 2'b00;
    localparam logic [1:0] STAT_HLT = 2'b01;
    localparam logic [1:0] STAT_ADR = 2'b10;
    localparam logic [1:0] STAT_INS = 2'b11;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_M_ACC = 2'd1,
        ARB_F_LO  = 2'd2,
        ARB_F_HI  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/addr_range_chk.sv
// rtl/addr_range_chk.sv - Checks that an access of SPAN bytes at i_addr lies inside memory.
module addr_range_chk #(
    parameter int ADDR_W   = 64,
    parameter int MEM_SIZE = 8192,
    parameter int SPAN     = 8
) (
    input  logic [ADDR_W-1:0] i_addr,
    output logic              o_ok
);

    localparam logic [ADDR_W:0] LAST_OFS = (ADDR_W + 1)'(SPAN - 1);
    localparam logic [ADDR_W:0] LIMIT    = (ADDR_W + 1)'(MEM_SIZE);

    // One extra bit so an address near the top of the space cannot wrap back in range.
    logic [ADDR_W:0] w_last;

    assign w_last = {1'b0, i_addr} + LAST_OFS;
    assign o_ok   = (w_last < LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - Shares one memory port between instruction fetch (10 bytes)
// and the memory stage (8 bytes), memory stage first.
module mem_port_arbiter
    import y86_pkg::*;
#(
    parameter int MEM_SIZE = 8192,
    parameter int ADDR_W   = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_valid,
    output logic [79:0]       f_rdata,
    output logic [1:0]        f_stat,
    output logic              f_wait,
    input  logic              m_req,
    input  logic              m_we,
    input  logic [ADDR_W-1:0] m_addr,
    input  logic [63:0]       m_wdata,
    output logic              m_valid,
    output logic [63:0]       m_rdata,
    output logic [1:0]        m_stat,
    output logic              m_wait,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [63:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [63:0]       mem_rdata
);

    localparam logic [ADDR_W-1:0] HI_OFS = ADDR_W'(8);

    arb_state_t        r_state, w_state_nxt;
    logic              r_mem_req, w_mem_req_nxt;
    logic              r_mem_we, w_mem_we_nxt;
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
    logic [63:0]       r_mem_wdata, w_mem_wdata_nxt;
    logic [ADDR_W-1:0] r_f_addr, w_f_addr_nxt;
    logic [63:0]       r_lo, w_lo_nxt;
    logic [79:0]       r_f_rdata, w_f_rdata_nxt;
    logic [1:0]        r_f_stat, w_f_stat_nxt;
    logic              r_f_valid, w_f_valid_nxt;
    logic [63:0]       r_m_rdata, w_m_rdata_nxt;
    logic [1:0]        r_m_stat, w_m_stat_nxt;
    logic              r_m_valid, w_m_valid_nxt;
    logic              w_m_ok;
    logic              w_f_ok;

    addr_range_chk #(
        .ADDR_W  (ADDR_W),
        .MEM_SIZE(MEM_SIZE),
        .SPAN    (8)
    ) u_m_chk (
        .i_addr(m_addr),
        .o_ok  (w_m_ok)
    );

    addr_range_chk #(
        .ADDR_W  (ADDR_W),
        .MEM_SIZE(MEM_SIZE),
        .SPAN    (10)
    ) u_f_chk (
        .i_addr(f_addr),
        .o_ok  (w_f_ok)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_mem_req_nxt   = r_mem_req;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_f_addr_nxt    = r_f_addr;
        w_lo_nxt        = r_lo;
        w_f_rdata_nxt   = r_f_rdata;
        w_f_stat_nxt    = r_f_stat;
        w_f_valid_nxt   = 1'b0;
        w_m_rdata_nxt   = r_m_rdata;
        w_m_stat_nxt    = r_m_stat;
        w_m_valid_nxt   = 1'b0;
        unique case (r_state)
            ARB_IDLE: begin
                // A requester still holds its request during its valid cycle; skip that cycle.
                if (!r_f_valid && !r_m_valid) begin
                    if (m_req) begin
                        if (!w_m_ok) begin
                            w_m_stat_nxt  = STAT_ADR;
                            w_m_valid_nxt = 1'b1;
                        end else begin
                            w_state_nxt     = ARB_M_ACC;
                            w_mem_req_nxt   = 1'b1;
                            w_mem_we_nxt    = m_we;
                            w_mem_addr_nxt  = m_addr;
                            w_mem_wdata_nxt = m_wdata;
                        end
                    end else if (f_req) begin
                        if (!w_f_ok) begin
                            w_f_stat_nxt  = STAT_ADR;
                            w_f_valid_nxt = 1'b1;
                        end else begin
                            w_state_nxt    = ARB_F_LO;
                            w_mem_req_nxt  = 1'b1;
                            w_mem_we_nxt   = 1'b0;
                            w_mem_addr_nxt = f_addr;
                            w_f_addr_nxt   = f_addr;
                        end
                    end
                end
            end
            ARB_M_ACC: begin
                if (mem_ack) begin
                    if (!r_mem_we) begin
                        w_m_rdata_nxt = mem_rdata;
                    end
                    w_m_stat_nxt  = STAT_AOK;
                    w_m_valid_nxt = 1'b1;
                    w_mem_req_nxt = 1'b0;
                    w_mem_we_nxt  = 1'b0;
                    w_state_nxt   = ARB_IDLE;
                end
            end
            ARB_F_LO: begin
                if (mem_ack) begin
                    w_lo_nxt       = mem_rdata;
                    w_mem_addr_nxt = r_f_addr + HI_OFS;
                    w_state_nxt    = ARB_F_HI;
                end
            end
            ARB_F_HI: begin
                if (mem_ack) begin
                    w_f_rdata_nxt = {mem_rdata[15:0], r_lo};
                    w_f_stat_nxt  = STAT_AOK;
                    w_f_valid_nxt = 1'b1;
                    w_mem_req_nxt = 1'b0;
                    w_state_nxt   = ARB_IDLE;
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_f_addr    <= '0;
            r_lo        <= '0;
            r_f_rdata   <= '0;
            r_f_stat    <= STAT_AOK;
            r_f_valid   <= 1'b0;
            r_m_rdata   <= '0;
            r_m_stat    <= STAT_AOK;
            r_m_valid   <= 1'b0;
        end else begin
            r_mem_req   <= w_mem_req_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_f_addr    <= w_f_addr_nxt;
            r_lo        <= w_lo_nxt;
            r_f_rdata   <= w_f_rdata_nxt;
            r_f_stat    <= w_f_stat_nxt;
            r_f_valid   <= w_f_valid_nxt;
            r_m_rdata   <= w_m_rdata_nxt;
            r_m_stat    <= w_m_stat_nxt;
            r_m_valid   <= w_m_valid_nxt;
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign f_valid   = r_f_valid;
    assign f_rdata   = r_f_rdata;
    assign f_stat    = r_f_stat;
    assign m_valid   = r_m_valid;
    assign m_rdata   = r_m_rdata;
    assign m_stat    = r_m_stat;
    assign f_wait    = f_req & ~r_f_valid;
    assign m_wait    = m_req & ~r_m_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - Directed self-checking bench for mem_port_arbiter.
module tb_mem_port_arbiter;
    import y86_pkg::*;

    localparam int MEM_SIZE = 8192;
    localparam int ADDR_W   = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              f_req = 1'b0;
    logic [ADDR_W-1:0] f_addr = '0;
    logic              f_valid;
    logic [79:0]       f_rdata;
    logic [1:0]        f_stat;
    logic              f_wait;
    logic              m_req = 1'b0;
    logic              m_we = 1'b0;
    logic [ADDR_W-1:0] m_addr = '0;
    logic [63:0]       m_wdata = '0;
    logic              m_valid;
    logic [63:0]       m_rdata;
    logic [1:0]        m_stat;
    logic              m_wait;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [63:0]       mem_wdata;
    logic              mem_ack;
    logic [63:0]       mem_rdata;

    int total = 0;
    int bad   = 0;

    // Memory model: byte at address a reads as a[7:0]; the last written beat overrides its address.
    int          delay = 0;
    int          cnt = 0;
    logic        ack_en = 1'b1;
    logic        manual_ack = 1'b0;
    logic        model_ack = 1'b0;
    logic [63:0] model_rdata = '0;
    logic        wr_valid = 1'b0;
    logic [63:0] wr_addr = '0;
    logic [63:0] wr_data = '0;

    assign mem_ack   = ack_en ? model_ack : manual_ack;
    assign mem_rdata = model_rdata;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!mem_req || !ack_en) begin
            model_ack <= 1'b0;
            cnt <= 0;
        end else if (cnt >= delay) begin
            model_ack <= 1'b1;
            cnt <= 0;
            if (mem_we) begin
                wr_valid <= 1'b1;
                wr_addr  <= mem_addr;
                wr_data  <= mem_wdata;
            end
            if (wr_valid && mem_addr == wr_addr) begin
                model_rdata <= wr_data;
            end else begin
                for (int k = 0; k < 8; k++) begin
                    model_rdata[k*8 +: 8] <= mem_addr[7:0] + 8'(k);
                end
            end
        end else begin
            model_ack <= 1'b0;
            cnt <= cnt + 1;
        end
    end

    mem_port_arbiter #(
        .MEM_SIZE(MEM_SIZE),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .f_req    (f_req),
        .f_addr   (f_addr),
        .f_valid  (f_valid),
        .f_rdata  (f_rdata),
        .f_stat   (f_stat),
        .f_wait   (f_wait),
        .m_req    (m_req),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_valid  (m_valid),
        .m_rdata  (m_rdata),
        .m_stat   (m_stat),
        .m_wait   (m_wait),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req got=%b want=0", mem_req); end
        total++; if (f_valid !== 1'b0) begin bad++; $display("FAIL reset_f_valid got=%b want=0", f_valid); end
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid got=%b want=0", m_valid); end
        total++; if (f_stat !== STAT_AOK) begin bad++; $display("FAIL reset_f_stat got=%b want=00", f_stat); end
        total++; if (m_stat !== STAT_AOK) begin bad++; $display("FAIL reset_m_stat got=%b want=00", m_stat); end
        total++; if (f_rdata !== 80'h0) begin bad++; $display("FAIL reset_f_rdata got=%h want=0", f_rdata); end
        total++; if (mem_addr !== 64'h0) begin bad++; $display("FAIL reset_mem_addr got=%h want=0", mem_addr); end
        total++; if (f_wait !== 1'b0) begin bad++; $display("FAIL reset_f_wait got=%b want=0", f_wait); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_fetch();
        f_req = 1'b1;
        f_addr = 64'h100;
        step();
        total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL fetch_lo_req got=%b want=1", mem_req); end
        total++; if (mem_addr !== 64'h100) begin bad++; $display("FAIL fetch_lo_addr got=%h want=100", mem_addr); end
        total++; if (f_wait !== 1'b1) begin bad++; $display("FAIL fetch_wait got=%b want=1", f_wait); end
        step();
        total++; if (mem_addr !== 64'h108) begin bad++; $display("FAIL fetch_hi_addr got=%h want=108", mem_addr); end
        total++; if (f_valid !== 1'b0) begin bad++; $display("FAIL fetch_early_valid got=%b want=0", f_valid); end
        step();
        total++; if (f_valid !== 1'b1) begin bad++; $display("FAIL fetch_valid got=%b want=1", f_valid); end
        total++; if (f_rdata !== 80'h09080706050403020100) begin bad++; $display("FAIL fetch_rdata got=%h want=09080706050403020100", f_rdata); end
        total++; if (f_stat !== STAT_AOK) begin bad++; $display("FAIL fetch_stat got=%b want=00", f_stat); end
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL fetch_req_drop got=%b want=0", mem_req); end
        f_req = 1'b0;
        step();
        total++; if (f_valid !== 1'b0) begin bad++; $display("FAIL fetch_valid_pulse got=%b want=0", f_valid); end
    endtask

    task automatic test_back_to_back();
        m_req = 1'b1;
        m_we = 1'b0;
        m_addr = 64'h208;
        step();
        total++; if (mem_addr !== 64'h208) begin bad++; $display("FAIL b2b_addr1 got=%h want=208", mem_addr); end
        total++; if (m_wait !== 1'b1) begin bad++; $display("FAIL b2b_wait got=%b want=1", m_wait); end
        step();
        total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid1 got=%b want=1", m_valid); end
        total++; if (m_rdata !== 64'h0F0E0D0C0B0A0908) begin bad++; $display("FAIL b2b_rdata1 got=%h want=0f0e0d0c0b0a0908", m_rdata); end
        m_addr = 64'h210;
        step();
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL b2b_gap got=%b want=0", mem_req); end
        step();
        total++; if (mem_addr !== 64'h210 || mem_req !== 1'b1) begin bad++; $display("FAIL b2b_regrant got=%b/%h want=1/210", mem_req, mem_addr); end
        step();
        total++; if (m_rdata !== 64'h1716151413121110) begin bad++; $display("FAIL b2b_rdata2 got=%h want=1716151413121110", m_rdata); end
        m_req = 1'b0;
        step();
    endtask

    task automatic test_simultaneous();
        m_req = 1'b1;
        m_we = 1'b1;
        m_addr = 64'h1F00;
        m_wdata = 64'hDEADBEEF;
        f_req = 1'b1;
        f_addr = 64'h100;
        step();
        total++; if (mem_addr !== 64'h1F00 || mem_we !== 1'b1) begin bad++; $display("FAIL sim_write_beat got=%h/%b want=1f00/1", mem_addr, mem_we); end
        total++; if (mem_wdata !== 64'hDEADBEEF) begin bad++; $display("FAIL sim_wdata got=%h want=deadbeef", mem_wdata); end
        total++; if (f_wait !== 1'b1) begin bad++; $display("FAIL sim_f_wait1 got=%b want=1", f_wait); end
        step();
        total++; if (m_valid !== 1'b1 || m_stat !== STAT_AOK) begin bad++; $display("FAIL sim_m_valid got=%b/%b want=1/00", m_valid, m_stat); end
        total++; if (f_wait !== 1'b1) begin bad++; $display("FAIL sim_f_wait2 got=%b want=1", f_wait); end
        m_req = 1'b0;
        m_we = 1'b0;
        step();
        total++; if (mem_req !== 1'b0 || f_wait !== 1'b1) begin bad++; $display("FAIL sim_gap got=%b/%b want=0/1", mem_req, f_wait); end
        step();
        total++; if (mem_req !== 1'b1 || mem_addr !== 64'h100 || mem_we !== 1'b0) begin bad++; $display("FAIL sim_fetch_lo got=%b/%h/%b want=1/100/0", mem_req, mem_addr, mem_we); end
        step();
        total++; if (mem_addr !== 64'h108 || f_wait !== 1'b1) begin bad++; $display("FAIL sim_fetch_hi got=%h/%b want=108/1", mem_addr, f_wait); end
        step();
        total++; if (f_valid !== 1'b1 || f_rdata !== 80'h09080706050403020100) begin bad++; $display("FAIL sim_fetch_done got=%b/%h want=1/09080706050403020100", f_valid, f_rdata); end
        f_req = 1'b0;
        step();
        m_req = 1'b1;
        m_addr = 64'h1F00;
        step();
        step();
        total++; if (m_rdata !== 64'h00000000DEADBEEF) begin bad++; $display("FAIL sim_readback got=%h want=00000000deadbeef", m_rdata); end
        m_req = 1'b0;
        step();
    endtask

    task automatic test_adr();
        m_req = 1'b1;
        m_addr = 64'(MEM_SIZE - 4);
        step();
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL adr_m_no_req got=%b want=0", mem_req); end
        total++; if (m_valid !== 1'b1 || m_stat !== STAT_ADR) begin bad++; $display("FAIL adr_m_resp got=%b/%b want=1/10", m_valid, m_stat); end
        total++; if (m_rdata !== 64'h00000000DEADBEEF) begin bad++; $display("FAIL adr_m_rdata_held got=%h want=00000000deadbeef", m_rdata); end
        m_req = 1'b0;
        step();
        m_req = 1'b1;
        m_addr = 64'h1FF8;
        step();
        step();
        total++; if (m_valid !== 1'b1 || m_stat !== STAT_AOK || m_rdata !== 64'hFFFEFDFCFBFAF9F8) begin bad++; $display("FAIL adr_m_edge got=%b/%b/%h want=1/00/fffefdfcfbfaf9f8", m_valid, m_stat, m_rdata); end
        m_req = 1'b0;
        step();
        f_req = 1'b1;
        f_addr = 64'hFFFF_FFFF_FFFF_FFFA;
        step();
        total++; if (f_valid !== 1'b1 || f_stat !== STAT_ADR || mem_req !== 1'b0) begin bad++; $display("FAIL adr_f_wrap got=%b/%b/%b want=1/10/0", f_valid, f_stat, mem_req); end
        total++; if (f_rdata !== 80'h09080706050403020100) begin bad++; $display("FAIL adr_f_rdata_held got=%h want=09080706050403020100", f_rdata); end
        f_req = 1'b0;
        step();
        f_req = 1'b1;
        f_addr = 64'h1FF7;
        step();
        total++; if (f_valid !== 1'b1 || f_stat !== STAT_ADR || mem_req !== 1'b0) begin bad++; $display("FAIL adr_f_edge got=%b/%b/%b want=1/10/0", f_valid, f_stat, mem_req); end
        f_req = 1'b0;
        step();
        f_req = 1'b1;
        f_addr = 64'h1FF6;
        step();
        step();
        step();
        total++; if (f_valid !== 1'b1 || f_stat !== STAT_AOK || f_rdata !== 80'hFFFEFDFCFBFAF9F8F7F6) begin bad++; $display("FAIL adr_f_last got=%b/%b/%h want=1/00/fffefdfcfbfaf9f8f7f6", f_valid, f_stat, f_rdata); end
        f_req = 1'b0;
        step();
    endtask

    task automatic test_wait_states();
        int n_lo = 0;
        int n_hi = 0;
        int n_other = 0;
        int n_valid = 0;
        delay = 5;
        f_req = 1'b1;
        f_addr = 64'h100;
        for (int i = 0; i < 30; i++) begin
            step();
            if (mem_req && mem_addr == 64'h100) n_lo++;
            else if (mem_req && mem_addr == 64'h108) n_hi++;
            else if (mem_req) n_other++;
            if (f_valid) begin
                n_valid++;
                total++; if (f_rdata !== 80'h09080706050403020100) begin bad++; $display("FAIL wait_rdata got=%h want=09080706050403020100", f_rdata); end
                f_req = 1'b0;
            end
        end
        total++; if (n_lo !== 6) begin bad++; $display("FAIL wait_lo_cycles got=%0d want=6", n_lo); end
        total++; if (n_hi !== 6) begin bad++; $display("FAIL wait_hi_cycles got=%0d want=6", n_hi); end
        total++; if (n_other !== 0) begin bad++; $display("FAIL wait_addr_stable got=%0d want=0", n_other); end
        total++; if (n_valid !== 1) begin bad++; $display("FAIL wait_valid_count got=%0d want=1", n_valid); end
        f_req = 1'b0;
        delay = 0;
        step();
    endtask

    task automatic test_reset_mid_fetch();
        delay = 3;
        f_req = 1'b1;
        f_addr = 64'h100;
        for (int i = 0; i < 5; i++) step();
        total++; if (mem_req !== 1'b1 || mem_addr !== 64'h108) begin bad++; $display("FAIL rmid_in_hi got=%b/%h want=1/108", mem_req, mem_addr); end
        rst = 1'b1;
        f_req = 1'b0;
        step();
        total++; if (mem_req !== 1'b0 || mem_addr !== 64'h0) begin bad++; $display("FAIL rmid_mem got=%b/%h want=0/0", mem_req, mem_addr); end
        total++; if (f_valid !== 1'b0 || f_rdata !== 80'h0 || m_rdata !== 64'h0) begin bad++; $display("FAIL rmid_outs got=%b/%h/%h want=0/0/0", f_valid, f_rdata, m_rdata); end
        total++; if (f_stat !== STAT_AOK || m_stat !== STAT_AOK) begin bad++; $display("FAIL rmid_stat got=%b/%b want=00/00", f_stat, m_stat); end
        rst = 1'b0;
        ack_en = 1'b0;
        manual_ack = 1'b1;
        step();
        total++; if (mem_req !== 1'b0 || f_valid !== 1'b0) begin bad++; $display("FAIL rmid_late_ack got=%b/%b want=0/0", mem_req, f_valid); end
        manual_ack = 1'b0;
        step();
        total++; if (f_valid !== 1'b0 || m_valid !== 1'b0 || mem_req !== 1'b0) begin bad++; $display("FAIL rmid_idle got=%b/%b/%b want=0/0/0", f_valid, m_valid, mem_req); end
        ack_en = 1'b1;
        delay = 0;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_back_to_back();
        test_simultaneous();
        test_adr();
        test_wait_states();
        test_reset_mid_fetch();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
